// File: rtl/g15_photo_pkg.sv
// g15_photo_pkg: shared types and helpers for the G-15 photo tape reader
package g15_photo_pkg;

    typedef enum logic [2:0] {IDLE, ACCEL, HOLE, GAP, REWIND, END} photo_state_e;

    typedef logic [4:0] tape_frame_t;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/g15_tape_store.sv
// g15_tape_store: tape image RAM, one write port and one registered read port
module g15_tape_store
    import g15_photo_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  tape_frame_t   wdata,
    input  logic [AW-1:0] raddr,
    output tape_frame_t   rdata
);

    tape_frame_t mem [DEPTH];

    // write appended frames; read is always one cycle behind the address
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/g15_photo_reader.sv
// g15_photo_reader: photoelectric tape reader emulation behind connector PL6
module g15_photo_reader
    import g15_photo_pkg::*;
#(
    parameter int TAPE_DEPTH = 4096,
    parameter int START_MS   = 10,
    parameter int FRAME_MS   = 4,
    parameter int HOLE_MS    = 2,
    parameter int REV_MS     = 1
) (
    input  logic                        CLOCK,
    input  logic                        rst,
    input  logic                        tick_ms,
    input  logic                        PL6_9_PHOTO_TAPE_FWD,
    input  logic                        PL6_10_PHOTO_TAPE_REV,
    input  logic                        PL6_11_REMOTE_REWIND,
    output logic                        PL6_1_PHOTO1,
    output logic                        PL6_2_PHOTO2,
    output logic                        PL6_4_PHOTO3,
    output logic                        PL6_5_PHOTO4,
    output logic                        PL6_7_PHOTO5,
    output logic                        PL6_18_WAIT_FOR_TAPE,
    input  logic                        load_valid,
    input  logic [4:0]                  load_data,
    output logic                        load_ready,
    input  logic                        load_clear,
    output logic [$clog2(TAPE_DEPTH):0] tape_pos,
    output logic [$clog2(TAPE_DEPTH):0] tape_len,
    output logic                        tape_end
);

    localparam int AW     = addr_w(TAPE_DEPTH);
    localparam int PW     = $clog2(TAPE_DEPTH) + 1;
    localparam int MAX_MS = (START_MS > FRAME_MS) ? ((START_MS > REV_MS) ? START_MS : REV_MS)
                                                  : ((FRAME_MS > REV_MS) ? FRAME_MS : REV_MS);
    localparam int CW     = $clog2(MAX_MS + 1);

    photo_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pos_q, pos_d, len_q, len_d;
    logic          dir_q, dir_d;
    tape_frame_t   photo_q, photo_d, rdata;
    logic          wait_q, tape_end_q, load_ready_q, load_ready_d;
    logic          rev, fwd, load_we, start_frame, turn;

    // reverse wins over forward when both relays are energized
    assign rev = PL6_10_PHOTO_TAPE_REV | PL6_11_REMOTE_REWIND;
    assign fwd = PL6_9_PHOTO_TAPE_FWD & ~rev;

    g15_tape_store #(.DEPTH(TAPE_DEPTH), .AW(AW)) u_store (
        .clk   (CLOCK),
        .we    (load_we),
        .waddr (len_q[AW-1:0]),
        .wdata (load_data),
        .raddr (pos_q[AW-1:0]),
        .rdata (rdata)
    );

    // next-state, tick interval counting, position and loading
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pos_d       = pos_q;
        len_d       = len_q;
        dir_d       = dir_q;
        photo_d     = photo_q;
        load_we     = 1'b0;
        start_frame = 1'b0;
        turn        = 1'b0;
        if (state_q == IDLE) begin
            if (load_clear) begin
                len_d = '0;
                pos_d = '0;
            end else if (load_valid && load_ready_q) begin
                load_we = 1'b1;
                len_d   = len_q + PW'(1);
            end
            if (fwd || rev) begin
                state_d = ACCEL;
                dir_d   = rev;
                cnt_d   = '0;
            end
        end else if (!fwd && !rev) begin
            state_d = IDLE;
            photo_d = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ACCEL: begin
                    if (rev != dir_q) turn = 1'b1;
                    else if (tick_ms) begin
                        if (cnt_q == CW'(START_MS - 1)) begin
                            cnt_d = '0;
                            if (rev) state_d = REWIND;
                            else start_frame = 1'b1;
                        end else cnt_d = cnt_q + CW'(1);
                    end
                end
                HOLE: begin
                    if (rev) turn = 1'b1;
                    else if (tick_ms) begin
                        if (cnt_q == CW'(HOLE_MS - 1)) begin
                            state_d = GAP;
                            photo_d = '0;
                            cnt_d   = '0;
                        end else cnt_d = cnt_q + CW'(1);
                    end
                end
                GAP: begin
                    if (rev) turn = 1'b1;
                    else if (tick_ms) begin
                        if (cnt_q == CW'(FRAME_MS - HOLE_MS - 1)) start_frame = 1'b1;
                        else cnt_d = cnt_q + CW'(1);
                    end
                end
                REWIND: begin
                    if (fwd) turn = 1'b1;
                    else if (tick_ms) begin
                        if (cnt_q == CW'(REV_MS - 1)) begin
                            cnt_d = '0;
                            if (pos_q != '0) pos_d = pos_q - PW'(1);
                        end else cnt_d = cnt_q + CW'(1);
                    end
                end
                END: if (rev) turn = 1'b1;
                default: ;
            endcase
            if (turn) begin
                state_d = ACCEL;
                dir_d   = rev;
                cnt_d   = '0;
                photo_d = '0;
            end
            if (start_frame) begin
                cnt_d = '0;
                if (pos_q >= len_q) state_d = END;
                else begin
                    state_d = HOLE;
                    photo_d = rdata;
                    pos_d   = pos_q + PW'(1);
                end
            end
        end
        load_ready_d = (state_d == IDLE) && (len_d < PW'(TAPE_DEPTH));
    end

    // state and registered outputs; tape memory is deliberately left intact
    always_ff @(posedge CLOCK) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pos_q        <= '0;
            len_q        <= '0;
            dir_q        <= 1'b0;
            photo_q      <= '0;
            wait_q       <= 1'b0;
            tape_end_q   <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pos_q        <= pos_d;
            len_q        <= len_d;
            dir_q        <= dir_d;
            photo_q      <= photo_d;
            wait_q       <= PL6_9_PHOTO_TAPE_FWD | rev;
            tape_end_q   <= (state_d == END);
            load_ready_q <= load_ready_d;
        end
    end

    assign PL6_1_PHOTO1         = photo_q[0];
    assign PL6_2_PHOTO2         = photo_q[1];
    assign PL6_4_PHOTO3         = photo_q[2];
    assign PL6_5_PHOTO4         = photo_q[3];
    assign PL6_7_PHOTO5         = photo_q[4];
    assign PL6_18_WAIT_FOR_TAPE = wait_q;
    assign load_ready           = load_ready_q;
    assign tape_pos             = pos_q;
    assign tape_len             = len_q;
    assign tape_end             = tape_end_q;

endmodule

// File: tb/tb_g15_photo_reader.sv
// tb_g15_photo_reader: scenario tests for the photo tape reader with a frame scoreboard
module tb_g15_photo_reader;

    localparam int DEPTH = 16;
    localparam int PW    = $clog2(DEPTH) + 1;

    logic          CLOCK = 1'b0;
    logic          rst = 1'b1, tick_ms = 1'b0, fwd_i = 1'b0, rev_i = 1'b0, rew_i = 1'b0;
    logic          load_valid = 1'b0, load_clear = 1'b0;
    logic [4:0]    load_data = '0;
    logic          p1, p2, p3, p4, p5, wait_o, load_ready, tape_end;
    logic [PW-1:0] tape_pos, tape_len;
    logic [4:0]    photo;

    int            vectors = 0, miscompares = 0;
    logic [4:0]    model_mem [DEPTH];
    int            model_len = 0, model_pos = 0;
    logic [4:0]    exp_q [$];

    assign photo = {p5, p4, p3, p2, p1};

    g15_photo_reader #(.TAPE_DEPTH(DEPTH)) dut (
        .CLOCK                 (CLOCK),
        .rst                   (rst),
        .tick_ms               (tick_ms),
        .PL6_9_PHOTO_TAPE_FWD  (fwd_i),
        .PL6_10_PHOTO_TAPE_REV (rev_i),
        .PL6_11_REMOTE_REWIND  (rew_i),
        .PL6_1_PHOTO1          (p1),
        .PL6_2_PHOTO2          (p2),
        .PL6_4_PHOTO3          (p3),
        .PL6_5_PHOTO4          (p4),
        .PL6_7_PHOTO5          (p5),
        .PL6_18_WAIT_FOR_TAPE  (wait_o),
        .load_valid            (load_valid),
        .load_data             (load_data),
        .load_ready            (load_ready),
        .load_clear            (load_clear),
        .tape_pos              (tape_pos),
        .tape_len              (tape_len),
        .tape_end              (tape_end)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic tick1();
        tick_ms = 1'b1;
        step();
        tick_ms = 1'b0;
        step();
    endtask

    task automatic accel_ticks(output logic seen);
        seen = 1'b0;
        repeat (9) begin
            tick1();
            if (photo !== 5'h00) seen = 1'b1;
        end
    endtask

    task automatic push_frame();
        exp_q.push_back(model_mem[model_pos]);
        model_pos++;
        tick1();
    endtask

    task automatic load_frame(input logic [4:0] d);
        load_data  = d;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        model_mem[model_len] = d;
        model_len++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vectors++;
        if ({photo, wait_o, tape_end, load_ready} !== 8'b0000_0001) begin
            miscompares++;
            $display("FAIL reset_outputs got=%b want=00000001", {photo, wait_o, tape_end, load_ready});
        end
        vectors++;
        if (tape_pos !== '0 || tape_len !== '0) begin
            miscompares++;
            $display("FAIL reset_pos_len got pos=%0d len=%0d want 0 0", tape_pos, tape_len);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_forward();
        logic seen;
        logic [4:0] e;
        load_frame(5'h01);
        load_frame(5'h1F);
        load_frame(5'h0A);
        vectors++;
        if (tape_len !== PW'(3)) begin
            miscompares++;
            $display("FAIL load_len got=%0d want=3", tape_len);
        end
        fwd_i = 1'b1;
        step();
        vectors++;
        if (wait_o !== 1'b1) begin
            miscompares++;
            $display("FAIL fwd_wait got=%b want=1", wait_o);
        end
        accel_ticks(seen);
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL fwd_accel_dark got photo activity want none");
        end
        for (int i = 0; i < 3; i++) begin
            push_frame();
            e = exp_q.pop_front();
            vectors++;
            if (photo !== e || tape_pos !== PW'(model_pos)) begin
                miscompares++;
                $display("FAIL fwd_frame%0d got=%h pos=%0d want=%h pos=%0d", i, photo, tape_pos, e, model_pos);
            end
            tick1();
            vectors++;
            if (photo !== e) begin
                miscompares++;
                $display("FAIL fwd_hold%0d got=%h want=%h", i, photo, e);
            end
            tick1();
            vectors++;
            if (photo !== 5'h00) begin
                miscompares++;
                $display("FAIL fwd_gap%0d got=%h want=00", i, photo);
            end
            tick1();
            vectors++;
            if (photo !== 5'h00 || wait_o !== 1'b1) begin
                miscompares++;
                $display("FAIL fwd_gap2_%0d got photo=%h wait=%b want 00 1", i, photo, wait_o);
            end
        end
        tick1();
        tick1();
        vectors++;
        if ({tape_end, photo} !== 6'b1_00000 || tape_pos !== PW'(3) || wait_o !== 1'b1) begin
            miscompares++;
            $display("FAIL fwd_end got end=%b photo=%h pos=%0d wait=%b want 1 00 3 1", tape_end, photo, tape_pos, wait_o);
        end
        fwd_i = 1'b0;
        step();
        vectors++;
        if (tape_end !== 1'b0 || wait_o !== 1'b0 || tape_pos !== PW'(3)) begin
            miscompares++;
            $display("FAIL fwd_release got end=%b wait=%b pos=%0d want 0 0 3", tape_end, wait_o, tape_pos);
        end
    endtask

    task automatic test_rewind();
        logic seen;
        rew_i = 1'b1;
        step();
        accel_ticks(seen);
        tick1();
        vectors++;
        if (seen !== 1'b0 || tape_pos !== PW'(3) || wait_o !== 1'b1) begin
            miscompares++;
            $display("FAIL rew_accel got pos=%0d wait=%b dirty=%b want 3 1 0", tape_pos, wait_o, seen);
        end
        for (int k = 2; k >= 0; k--) begin
            tick1();
            vectors++;
            if (tape_pos !== PW'(k) || photo !== 5'h00) begin
                miscompares++;
                $display("FAIL rew_step got pos=%0d photo=%h want %0d 00", tape_pos, photo, k);
            end
        end
        tick1();
        tick1();
        vectors++;
        if (tape_pos !== '0) begin
            miscompares++;
            $display("FAIL rew_leader got pos=%0d want 0", tape_pos);
        end
        rew_i = 1'b0;
        step();
        model_pos = 0;
    endtask

    task automatic test_drop_mid_hole();
        logic seen;
        logic [4:0] e;
        fwd_i = 1'b1;
        step();
        accel_ticks(seen);
        push_frame();
        e = exp_q.pop_front();
        repeat (3) tick1();
        push_frame();
        e = exp_q.pop_front();
        vectors++;
        if (photo !== e || tape_pos !== PW'(2)) begin
            miscompares++;
            $display("FAIL drop_frame2 got=%h pos=%0d want=%h pos=2", photo, tape_pos, e);
        end
        fwd_i = 1'b0;
        step();
        vectors++;
        if (photo !== 5'h00 || wait_o !== 1'b0 || tape_pos !== PW'(2) || load_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_idle got photo=%h wait=%b pos=%0d rdy=%b want 00 0 2 1", photo, wait_o, tape_pos, load_ready);
        end
        fwd_i = 1'b1;
        step();
        accel_ticks(seen);
        push_frame();
        e = exp_q.pop_front();
        vectors++;
        if (seen !== 1'b0 || photo !== e || tape_pos !== PW'(3)) begin
            miscompares++;
            $display("FAIL drop_resume got=%h pos=%0d dirty=%b want=%h pos=3 0", photo, tape_pos, seen, e);
        end
        fwd_i = 1'b0;
        step();
    endtask

    task automatic test_fwd_rev_together();
        logic seen;
        fwd_i = 1'b1;
        rev_i = 1'b1;
        step();
        accel_ticks(seen);
        tick1();
        tick1();
        vectors++;
        if (tape_pos !== PW'(2) || photo !== 5'h00 || wait_o !== 1'b1) begin
            miscompares++;
            $display("FAIL both_rev got pos=%0d photo=%h wait=%b want 2 00 1", tape_pos, photo, wait_o);
        end
        fwd_i   = 1'b0;
        rev_i   = 1'b0;
        tick_ms = 1'b1;
        step();
        tick_ms = 1'b0;
        vectors++;
        if (tape_pos !== PW'(2) || load_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL tick_drop got pos=%0d rdy=%b want 2 1", tape_pos, load_ready);
        end
        fwd_i = 1'b1;
        rev_i = 1'b1;
        step();
        accel_ticks(seen);
        repeat (4) tick1();
        vectors++;
        if (tape_pos !== '0 || photo !== 5'h00) begin
            miscompares++;
            $display("FAIL both_leader got pos=%0d photo=%h want 0 00", tape_pos, photo);
        end
        fwd_i = 1'b0;
        rev_i = 1'b0;
        step();
        model_pos = 0;
    endtask

    task automatic test_load_while_moving();
        logic seen;
        logic [4:0] e;
        fwd_i = 1'b1;
        step();
        vectors++;
        if (load_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL move_ready got=%b want=0", load_ready);
        end
        load_data  = 5'h15;
        load_valid = 1'b1;
        load_clear = 1'b1;
        step();
        load_valid = 1'b0;
        load_clear = 1'b0;
        vectors++;
        if (tape_len !== PW'(3)) begin
            miscompares++;
            $display("FAIL move_len got=%0d want=3", tape_len);
        end
        accel_ticks(seen);
        push_frame();
        e = exp_q.pop_front();
        vectors++;
        if (photo !== e || tape_pos !== PW'(1)) begin
            miscompares++;
            $display("FAIL move_frame got=%h pos=%0d want=%h pos=1", photo, tape_pos, e);
        end
        fwd_i = 1'b0;
        step();
        load_clear = 1'b1;
        step();
        load_clear = 1'b0;
        vectors++;
        if (tape_len !== '0 || tape_pos !== '0 || load_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL clear got len=%0d pos=%0d rdy=%b want 0 0 1", tape_len, tape_pos, load_ready);
        end
        model_len = 0;
        model_pos = 0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) load_frame(5'(i + 1));
        vectors++;
        if (tape_len !== PW'(DEPTH) || load_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fill got len=%0d rdy=%b want %0d 0", tape_len, load_ready, DEPTH);
        end
        load_data  = 5'h1E;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        vectors++;
        if (tape_len !== PW'(DEPTH)) begin
            miscompares++;
            $display("FAIL overfill got len=%0d want %0d", tape_len, DEPTH);
        end
    endtask

    task automatic test_reset_in_hole();
        logic seen;
        logic [4:0] e;
        fwd_i = 1'b1;
        step();
        accel_ticks(seen);
        push_frame();
        e = exp_q.pop_front();
        vectors++;
        if (photo !== e || photo === 5'h00) begin
            miscompares++;
            $display("FAIL rst_hole_frame got=%h want=%h", photo, e);
        end
        rst = 1'b1;
        step();
        vectors++;
        if ({photo, wait_o, tape_end, load_ready} !== 8'b0000_0001 || tape_len !== '0 || tape_pos !== '0) begin
            miscompares++;
            $display("FAIL rst_hole got=%b len=%0d pos=%0d want 00000001 0 0",
                     {photo, wait_o, tape_end, load_ready}, tape_len, tape_pos);
        end
        rst   = 1'b0;
        fwd_i = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_rewind();
        test_drop_mid_hole();
        test_fwd_rev_together();
        test_load_while_moving();
        test_fill();
        test_reset_in_hole();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
